// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared constants and encodings for the EX-stage multiply/divide sequencer.
package ex_muldiv_ctrl_pkg;

  localparam int MULDIV_DATA_W = 32;
  localparam int MULDIV_CNT_W  = 5;

  typedef enum logic [1:0] {
    OP_MUL_S = 2'b00,
    OP_MUL_U = 2'b01,
    OP_DIV_S = 2'b10,
    OP_DIV_U = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// One combinational step of the shift-add multiplier or restoring divider.
// acc = {high word, low word}: multiplier/product for MUL, remainder/quotient for DIV.
module muldiv_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0]   operand_i,
  input  logic                is_div_i,
  output logic [2*DATA_W-1:0] acc_o
);

  logic [DATA_W:0] add_sum;
  logic [DATA_W:0] rem_shift;
  logic [DATA_W:0] rem_diff;

  // Bit DATA_W of rem_diff is the borrow; rem_shift < 2*divisor keeps it exact.
  always_comb begin
    add_sum   = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + {1'b0, operand_i};
    rem_shift = acc_i[2*DATA_W-1:DATA_W-1];
    rem_diff  = rem_shift - {1'b0, operand_i};
    acc_o     = acc_i;
    if (is_div_i) begin
      if (rem_diff[DATA_W]) begin
        acc_o = {rem_shift[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b0};
      end else begin
        acc_o = {rem_diff[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b1};
      end
    end else if (acc_i[0]) begin
      acc_o = {add_sum, acc_i[DATA_W-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle mul/div sequencer for EX: stalls the pipe for 32 iterations plus
// a sign-fix cycle, then holds rl_o/rh_o with done_o until EX acknowledges.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = MULDIV_DATA_W,
  parameter int CNT_W  = MULDIV_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] oper1_i,
  input  logic [DATA_W-1:0] oper2_i,
  input  logic              ack_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rl_o,
  output logic [DATA_W-1:0] rh_o
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic                is_div_q, is_div_d;
  logic                neg_lo_q, neg_lo_d;
  logic                neg_hi_q, neg_hi_d;
  logic [DATA_W-1:0]   rl_q, rl_d;
  logic [DATA_W-1:0]   rh_q, rh_d;

  logic [2*DATA_W-1:0] acc_step;
  logic [2*DATA_W-1:0] prod_neg;
  logic                is_signed;
  logic                sign1, sign2;
  logic [DATA_W-1:0]   mag1, mag2;

  muldiv_iter_core #(.DATA_W(DATA_W)) u_iter (
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .is_div_i  (is_div_q),
    .acc_o     (acc_step)
  );

  // Magnitudes of the incoming operands; only meaningful on the start cycle.
  always_comb begin
    is_signed = ~op_i[0];
    sign1     = is_signed & oper1_i[DATA_W-1];
    sign2     = is_signed & oper2_i[DATA_W-1];
    mag1      = sign1 ? -oper1_i : oper1_i;
    mag2      = sign2 ? -oper2_i : oper2_i;
    prod_neg  = -acc_q;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    rl_d      = rl_q;
    rh_d      = rh_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          is_div_d = op_i[1];
          neg_lo_d = sign1 ^ sign2;
          count_d  = '0;
          state_d  = ST_CALC;
          // Remainder takes the dividend's sign; the product uses neg_lo only.
          if (op_i[1]) begin
            acc_d     = {{DATA_W{1'b0}}, mag1};
            operand_d = mag2;
            neg_hi_d  = sign1;
          end else begin
            acc_d     = {{DATA_W{1'b0}}, mag2};
            operand_d = mag1;
            neg_hi_d  = sign1 ^ sign2;
          end
        end
      end
      ST_CALC: begin
        acc_d   = acc_step;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(DATA_W-1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (is_div_q) begin
          rl_d = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
          rh_d = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        end else begin
          rl_d = neg_lo_q ? prod_neg[DATA_W-1:0] : acc_q[DATA_W-1:0];
          rh_d = neg_lo_q ? prod_neg[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        end
      end
      ST_DONE: begin
        if (ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      rl_q      <= '0;
      rh_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      rl_q      <= rl_d;
      rh_q      <= rh_d;
    end
  end

  assign stall_o = req_i & (state_q != ST_DONE) & ~flush_i & ~rst;
  assign done_o  = (state_q == ST_DONE);
  assign rl_o    = rl_q;
  assign rh_o    = rh_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: arithmetic results, latency, stall, flush,
// reset and back-to-back operation with hand-computed expectations.
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] oper1_i = '0;
  logic [31:0] oper2_i = '0;
  logic        ack_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rl_o;
  logic [31:0] rh_o;

  int checks = 0;
  int failures = 0;

  ex_muldiv_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .op_i    (op_i),
    .oper1_i (oper1_i),
    .oper2_i (oper2_i),
    .ack_i   (ack_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .done_o  (done_o),
    .rl_o    (rl_o),
    .rh_o    (rh_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op this cycle, scrambles the inputs afterwards and counts cycles
  // until done_o; stall_all records whether stall_o stayed high until then.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic stall_all);
    req_i = 1'b1;
    op_i = op;
    oper1_i = a;
    oper2_i = b;
    #1;
    stall_all = stall_o;
    lat = 0;
    while (done_o !== 1'b1 && lat < 60) begin
      tick();
      lat++;
      op_i = op ^ 2'b01;
      oper1_i = $urandom;
      oper2_i = $urandom;
      #1;
      if (done_o !== 1'b1) stall_all = stall_all & stall_o;
    end
  endtask

  task automatic finish_op();
    ack_i = 1'b1;
    req_i = 1'b0;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_i = 1'b1;
    oper1_i = 32'd5;
    oper2_i = 32'd6;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", stall_o); end
    tick();
    tick();
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done_o); end
    checks++;
    if (rl_o !== 32'h0 || rh_o !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_results got=%h/%h exp=0/0", rh_o, rl_o);
    end
    rst = 1'b0;
    req_i = 1'b0;
    tick();
  endtask

  task automatic test_mul_signed();
    int lat;
    logic st;
    run_op(2'b00, 32'd7, 32'hFFFFFFFD, lat, st);
    checks++;
    if (lat !== 34) begin failures++; $display("[TB] FAIL muls_latency got=%0d exp=34", lat); end
    checks++;
    if (st !== 1'b1) begin failures++; $display("[TB] FAIL muls_stall_busy got=%b exp=1", st); end
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("[TB] FAIL muls_stall_done got=%b exp=0", stall_o); end
    checks++;
    if (rh_o !== 32'hFFFFFFFF || rl_o !== 32'hFFFFFFEB) begin
      failures++; $display("[TB] FAIL muls_result got=%h_%h exp=ffffffff_ffffffeb", rh_o, rl_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done_o !== 1'b1 || rl_o !== 32'hFFFFFFEB || rh_o !== 32'hFFFFFFFF) begin
        failures++;
        $display("[TB] FAIL muls_hold done=%b got=%h_%h exp=1 ffffffff_ffffffeb", done_o, rh_o, rl_o);
      end
    end
    finish_op();
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL muls_ack got=%b exp=0", done_o); end
  endtask

  task automatic test_mul_unsigned();
    int lat;
    logic st;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, st);
    checks++;
    if (lat !== 34) begin failures++; $display("[TB] FAIL mulu_latency got=%0d exp=34", lat); end
    checks++;
    if (rh_o !== 32'hFFFFFFFE || rl_o !== 32'h00000001) begin
      failures++; $display("[TB] FAIL mulu_result got=%h_%h exp=fffffffe_00000001", rh_o, rl_o);
    end
    finish_op();
  endtask

  task automatic test_div_signed();
    logic [31:0] a [3] = '{32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFB};
    logic [31:0] b [3] = '{32'd2, 32'hFFFFFFFF, 32'd0};
    logic [31:0] q [3] = '{32'hFFFFFFFD, 32'h80000000, 32'h00000001};
    logic [31:0] r [3] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFB};
    int lat;
    logic st;
    for (int i = 0; i < 3; i++) begin
      run_op(2'b10, a[i], b[i], lat, st);
      checks++;
      if (lat !== 34 || rl_o !== q[i] || rh_o !== r[i]) begin
        failures++;
        $display("[TB] FAIL divs_%0d got lat=%0d q=%h r=%h exp lat=34 q=%h r=%h", i, lat, rl_o, rh_o, q[i], r[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_div_unsigned();
    logic [31:0] a [2] = '{32'd100, 32'd1000};
    logic [31:0] b [2] = '{32'd0, 32'd7};
    logic [31:0] q [2] = '{32'hFFFFFFFF, 32'd142};
    logic [31:0] r [2] = '{32'd100, 32'd6};
    int lat;
    logic st;
    for (int i = 0; i < 2; i++) begin
      run_op(2'b11, a[i], b[i], lat, st);
      checks++;
      if (lat !== 34 || st !== 1'b1 || rl_o !== q[i] || rh_o !== r[i]) begin
        failures++;
        $display("[TB] FAIL divu_%0d got lat=%0d stall=%b q=%h r=%h exp lat=34 stall=1 q=%h r=%h",
                 i, lat, st, rl_o, rh_o, q[i], r[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_flush();
    int lat;
    logic st;
    logic saw_done;
    req_i = 1'b1;
    op_i = 2'b11;
    oper1_i = 32'd1000;
    oper2_i = 32'd7;
    #1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      saw_done = saw_done | done_o;
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall got=%b exp=0", stall_o); end
    tick();
    flush_i = 1'b0;
    req_i = 1'b0;
    saw_done = saw_done | done_o;
    tick();
    run_op(2'b11, 32'd50, 32'd5, lat, st);
    checks++;
    if (saw_done !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_done got=%b exp=0", saw_done); end
    checks++;
    if (lat !== 34 || rl_o !== 32'd10 || rh_o !== 32'd0) begin
      failures++; $display("[TB] FAIL flush_restart got lat=%0d q=%h r=%h exp lat=34 q=a r=0", lat, rl_o, rh_o);
    end
    finish_op();
    // A request coinciding with flush must not start anything.
    req_i = 1'b1;
    flush_i = 1'b1;
    op_i = 2'b01;
    oper1_i = 32'd2;
    oper2_i = 32'd3;
    tick();
    req_i = 1'b0;
    flush_i = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      saw_done = saw_done | done_o;
    end
    checks++;
    if (saw_done !== 1'b0) begin failures++; $display("[TB] FAIL flush_req_start got=%b exp=0", saw_done); end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_i = 1'b1;
    op_i = 2'b01;
    oper1_i = 32'd3;
    oper2_i = 32'd5;
    #1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_stall got=%b exp=0", stall_o); end
    tick();
    rst = 1'b0;
    req_i = 1'b0;
    checks++;
    if (done_o !== 1'b0 || rl_o !== 32'h0 || rh_o !== 32'h0) begin
      failures++; $display("[TB] FAIL rstmid_outputs got done=%b %h_%h exp 0 0_0", done_o, rh_o, rl_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic st;
    run_op(2'b00, 32'hFFFFFFFA, 32'hFFFFFFF9, lat, st);
    checks++;
    if (lat !== 34 || rl_o !== 32'd42 || rh_o !== 32'd0) begin
      failures++; $display("[TB] FAIL b2b_first got lat=%0d %h_%h exp lat=34 0_2a", lat, rh_o, rl_o);
    end
    ack_i = 1'b1;
    req_i = 1'b1;
    op_i = 2'b01;
    oper1_i = 32'd3;
    oper2_i = 32'd4;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_stall got=%b exp=0", stall_o); end
    tick();
    ack_i = 1'b0;
    checks++;
    if (done_o !== 1'b0 || stall_o !== 1'b1 || rl_o !== 32'd42) begin
      failures++; $display("[TB] FAIL b2b_idle got done=%b stall=%b rl=%h exp 0 1 2a", done_o, stall_o, rl_o);
    end
    run_op(2'b01, 32'd3, 32'd4, lat, st);
    checks++;
    if (lat !== 34 || st !== 1'b1 || rl_o !== 32'd12 || rh_o !== 32'd0) begin
      failures++; $display("[TB] FAIL b2b_second got lat=%0d stall=%b %h_%h exp lat=34 1 0_c", lat, st, rh_o, rl_o);
    end
    finish_op();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_mul_signed();
    test_mul_unsigned();
    test_div_signed();
    test_div_unsigned();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer attached to the EX stage of the single-issue pipeline.
- Accepts a mul/div request from EX and stalls EX while a 32-iteration shift-add or restoring-divide datapath runs.
- Returns the low word (product low / quotient) and high word (product high / remainder) for EX's regs_wdata_src selection of rl/rh.
- Releases the stall when results are ready, and supports flush from the pipeline controller.

Parameters:
- DATA_W, 32, operand/result word width; all counters are sized from it.
- CNT_W, 5, iteration counter width (log2 DATA_W).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  level; EX holds a valid mul/div instruction.
- op_i  in  2  00 MUL signed, 01 MUL unsigned, 10 DIV signed, 11 DIV unsigned.
- oper1_i  in  DATA_W  multiplicand/dividend; sampled on start only.
- oper2_i  in  DATA_W  multiplier/divisor; sampled on start only.
- ack_i  in  1  EX allowout; the instruction leaves EX this cycle.
- flush_i  in  1  cancel any operation in progress.
- stall_o  out  1  hold EX and the upstream stages.
- done_o  out  1  rl_o/rh_o valid.
- rl_o  out  DATA_W  product[31:0] or quotient.
- rh_o  out  DATA_W  product[63:32] or remainder.

Behaviour:
- Reset: the clock and reset are as already decided — one clock, clk; rst is synchronous, active-high. Reset forces state=IDLE, count=0, done_o=0, rl_o=0, rh_o=0, and stall_o=0 regardless of req_i.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - req_i=1 starts an operation.
  - Latch op_i, |oper1_i| and |oper2_i| (absolute values only for signed ops).
  - Latch result sign bits: MUL sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
  - count<=0, go to CALC.
- CALC: one iteration per cycle; count increments; after count==DATA_W-1 go to FIX. Exactly DATA_W cycles.
  - MUL: 64-bit accumulate, shift-add on the LSB of the multiplier.
  - DIV: restoring divide, shift partial remainder left, subtract divisor, set quotient bit if no borrow.
- FIX (1 cycle):
  - Apply two's-complement sign correction to the magnitudes.
  - Write rl_o/rh_o and go to DONE.
- DONE: done_o=1, and rl_o/rh_o are held stable.
  - ack_i=1 returns to IDLE with done_o=0 next cycle.
  - req_i is ignored while in DONE.
- Latency: req_i first seen in IDLE at cycle T → CALC T+1..T+32 → FIX T+33 → done_o=1 from T+34 until ack.
- stall_o = req_i & (state!=DONE) & ~flush_i, which is combinational. It is 1 during the start cycle and through FIX, and 0 in DONE.
- Back-to-back: ack in DONE → IDLE next cycle; if the next instruction's req_i is high then, it starts immediately with no bubble beyond the IDLE cycle.
- Divide by zero (oper2=0):
  - quotient=0xFFFFFFFF for unsigned; for signed, all-ones magnitude then sign-corrected.
  - remainder=oper1_i.
  - Same latency; no exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- flush_i:
  - Takes priority over everything except rst.
  - In any state, goes to IDLE next cycle with done_o=0; partial results are discarded.
  - A req_i asserted in the same cycle as flush_i does not start.
- Operands are sampled only at start; later changes on oper*_i have no effect.
- ack_i outside DONE is ignored.

Decomposition:
- Op encodings (MUL_S/MUL_U/DIV_S/DIV_U), state encodings and DATA_W go in the shared define header (`define constants alongside the existing width macros).
- One sub-module, muldiv_iter_core: the per-cycle shift-add/restoring-subtract datapath step, purely combinational, taking {acc, operand, mode} to {next acc}.
- ex_muldiv_ctrl holds the FSM, counter, sign handling and output registers.

Test Plan:
- MUL signed, 7 × 0xFFFFFFFD (−3) → done at T+34; rh_o=0xFFFFFFFF, rl_o=0xFFFFFFEB; stall_o high T..T+33, low at T+34.
- MUL unsigned, 0xFFFFFFFF × 0xFFFFFFFF → rh_o=0xFFFFFFFE, rl_o=0x00000001.
- DIV signed, 0xFFFFFFF9 (−7) / 2 → rl_o=0xFFFFFFFD, rh_o=0xFFFFFFFF. DIV signed, 0x80000000 / 0xFFFFFFFF → rl_o=0x80000000, rh_o=0.
- DIV unsigned, 100 / 0 → rl_o=0xFFFFFFFF, rh_o=100; latency unchanged.
- flush_i at cycle T+10 of a DIV → IDLE at T+11, done_o never asserts; a new req at T+12 yields a correct result at T+46. Also check rst asserted at T+5 clears all outputs.
- Back-to-back: ack_i in the first DONE cycle with req_i held high for a new MUL 3×4 → second start one cycle later; rl_o=12, rh_o=0; first results held stable until ack.
